// File: rtl/register_dump.sv
// Debug read-out engine: walks register-file indices and streams each word
// as a 5-byte frame (header + 4 data bytes, LSB first) over valid/ready.
module register_dump #(
    parameter int unsigned FIRST_REG = 1,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  read_address,
    input  logic [31:0] read_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  index_q, index_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            index_q    <= FIRST_IDX;
            byte_cnt_q <= 3'd0;
            word_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    index_d = FIRST_IDX;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                word_d     = read_data;
                byte_cnt_d = 3'd0;
                state_d    = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (byte_cnt_q == 3'd4) begin
                        byte_cnt_d = 3'd0;
                        if (index_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            index_d = index_q + 5'd1;
                            state_d = FETCH;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
            DONE: begin
                // Park the index so IDLE presents FIRST_REG on the read port.
                index_d = FIRST_IDX;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        out_valid    = (state_q == SEND);
        read_address = index_q;
        out_data     = 8'd0;
        if (state_q == SEND) begin
            case (byte_cnt_q)
                3'd0:    out_data = {3'b101, index_q};
                3'd1:    out_data = word_q[7:0];
                3'd2:    out_data = word_q[15:8];
                3'd3:    out_data = word_q[23:16];
                3'd4:    out_data = word_q[31:24];
                default: out_data = 8'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_register_dump.sv
// Bench for register_dump: byte-queue scoreboard built from the register
// file contents, plus directed scenarios with literal expectations.
module tb_register_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, ready;
    logic        busy, done, out_valid;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic [7:0]  od;

    logic        start1, ready1;
    logic        busy1, done1, out_valid1;
    logic [4:0]  ra1;
    logic [31:0] rd1;
    logic [7:0]  od1;

    logic [31:0] rf [32];
    assign rd  = rf[ra];
    assign rd1 = rf[ra1];

    register_dump dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done),
        .read_address(ra), .read_data(rd),
        .out_data(od), .out_valid(out_valid), .out_ready(ready)
    );

    register_dump #(.FIRST_REG(5), .LAST_REG(5)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .busy(busy1), .done(done1),
        .read_address(ra1), .read_data(rd1),
        .out_data(od1), .out_valid(out_valid1), .out_ready(ready1)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];
    bit         pending_done = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic [7:0] e_byte;
    int         busy_cnt = 0;
    int         done_cnt = 0;
    int         byte_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Expected stream of a dump, from the register file as it stands now.
    function automatic void arm(int f, int l);
        for (int i = f; i <= l; i++) begin
            exp_q.push_back(8'hA0 | 8'(i));
            exp_q.push_back(rf[i][7:0]);
            exp_q.push_back(rf[i][15:8]);
            exp_q.push_back(rf[i][23:16]);
            exp_q.push_back(rf[i][31:24]);
        end
    endfunction

    task automatic wait_idle(int maxc, string name);
        int n = 0;
        while (busy && n < maxc) begin
            step();
            n++;
        end
        chk(name, busy, 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            pending_done = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            chk("done_timing", done, pending_done);
            pending_done = 1'b0;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", od, prev_data);
            end
            if (out_valid && ready) begin
                byte_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %0h, required none", od);
                end else begin
                    e_byte = exp_q.pop_front();
                    chk("stream_byte", od, e_byte);
                    if (exp_q.size() == 0) pending_done = 1'b1;
                end
            end
            prev_stall = out_valid && !ready;
            prev_data  = od;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    logic [7:0] exp1 [5];
    logic [7:0] got [5];
    int         gcyc [5];
    int         ng;
    int         last_c;
    bit         found;
    int         n;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;
        exp1 = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

        // Reset dominance with start held high
        reset = 1'b0; start = 1'b1; ready = 1'b1;
        start1 = 1'b1; ready1 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_done", done, 0);
            chk("rst_addr", ra, 1);
            chk("rst_addr1", ra1, 5);
        end
        step();
        reset = 1'b1; start = 1'b0; start1 = 1'b0;
        step();

        // Single-register dump on the FIRST=LAST=5 instance
        rf[5] = 32'hDEADBEEF;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        ng = 0;
        last_c = -10;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid1 && ready1 && ng < 5) begin
                got[ng]  = od1;
                gcyc[ng] = c;
                ng++;
                if (ng == 5) last_c = c;
            end
            if (c == last_c + 1) chk("single_done", done1, 1);
            if (c == last_c + 2) begin
                chk("single_done_pulse", done1, 0);
                chk("single_idle", busy1, 0);
            end
        end
        chk("single_count", ng, 5);
        for (int k = 0; k < 5; k++) chk("single_byte", got[k], exp1[k]);
        chk("single_consecutive", gcyc[4] - gcyc[0], 4);
        rf[5] = 32'h05050505;
        step();

        // Backpressure on byte 02 of the first frame
        rf[1] = 32'h04030201;
        arm(1, 31);
        done_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        @(negedge clk);
        chk("bp_header", od, 8'hA1);
        step();
        step();
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_data", od, 8'h02);
            chk("bp_hold_valid", out_valid, 1);
            step();
        end
        ready = 1'b1;
        wait_idle(400, "bp_finish");
        chk("bp_done_cnt", done_cnt, 1);
        chk("bp_drained", exp_q.size(), 0);
        rf[1] = 32'h01010101;
        step();

        // Full default dump
        arm(1, 31);
        busy_cnt = 0; done_cnt = 0; byte_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(400, "full_finish");
        chk("full_busy_cycles", busy_cnt, 187);
        chk("full_done_cnt", done_cnt, 1);
        chk("full_bytes", byte_cnt, 155);
        chk("full_drained", exp_q.size(), 0);
        step();

        // Snapshot isolation: write reg3 while frame 3 is being sent
        arm(1, 31);
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            @(negedge clk);
            if (ra == 5'd3 && out_valid) found = 1'b1;
            n++;
        end
        chk("snap_reached", found, 1);
        rf[3] = 32'h11111111;
        wait_idle(400, "snap_finish");
        chk("snap_drained", exp_q.size(), 0);
        step();
        arm(1, 31);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(400, "snap2_finish");
        chk("snap2_drained", exp_q.size(), 0);
        rf[3] = 32'h03030303;
        step();

        // Abort during frame 10, then restart
        arm(1, 31);
        done_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            if (ra == 5'd10 && out_valid) found = 1'b1;
            n++;
        end
        chk("abort_reached", found, 1);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_idle", busy, 0);
        repeat (4) step();
        chk("abort_no_done", done_cnt, 0);
        arm(1, 31);
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 10) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
            n++;
        end
        chk("restart_valid", found, 1);
        chk("restart_header", od, 8'hA1);
        wait_idle(400, "restart_finish");
        chk("restart_done_cnt", done_cnt, 1);
        chk("restart_drained", exp_q.size(), 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_dump.md
# register_dump

Debug read-out engine for the CPU register file. On a start pulse it walks register indices FIRST_REG..LAST_REG through a spare register-file read port. It snapshots each 32-bit word and streams it out as byte frames over a valid/ready interface, sized for the 8-bit output pins. It sits beside the register file on the debug path and never writes to it.

## Interface
- FIRST_REG, default 1: first register index dumped (0..31).
- LAST_REG, default 31: last register index dumped (FIRST_REG..31).
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request a dump; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last byte of LAST_REG is accepted.
- read_address  output  5  register index to the register-file read port; equals internal index counter.
- read_data  input  32  combinational word from the register file for read_address.
- out_data  output  8  current byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts out_data this cycle.

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - busy=0, out_valid=0, read_address=FIRST_REG.
  - start=1 → index<=FIRST_REG, go to FETCH.
- FETCH, one cycle:
  - word register <= read_data (snapshot at this rising edge).
  - byte counter <= 0.
  - Go to SEND.
- SEND: out_valid=1. Frame per register is 5 bytes, in order:
  - byte 0, header: {3'b101, index[4:0]}.
  - bytes 1..4: word[7:0], word[15:8], word[23:16], word[31:24] (LSB first).
- Handshake:
  - A byte transfers on a rising edge with out_valid && out_ready.
  - out_data must not change while out_valid && !out_ready.
  - out_valid stays high until the transfer.
- After byte 4 transfers:
  - index==LAST_REG → DONE.
  - Otherwise index<=index+1 → FETCH.
- DONE, one cycle: done=1, busy=1, out_valid=0, then go to IDLE.
- start while busy is ignored and is not queued.
- The word is frozen from FETCH onward. Register-file writes during SEND do not affect the current frame; they are seen only by later registers' FETCH.
- Index arithmetic is 5-bit. Index never exceeds LAST_REG, so there is no wrap.
- FIRST_REG==LAST_REG → exactly one frame, then DONE.

## Timing
- Reset (reset=0 at a rising edge):
  - state=IDLE, index=FIRST_REG, byte counter=0, word=0.
  - busy=0, done=0, out_valid=0, out_data=0.
  - Reset takes priority over every other input.
- Reset mid-dump aborts immediately:
  - No further bytes are sent and done is not pulsed.
  - The next start begins again at FIRST_REG.
- Latency:
  - start sampled at edge N → FETCH during cycle N+1 → header valid in cycle N+2.
  - With out_ready held high, one register costs 6 cycles (1 FETCH + 5 SEND).
  - Full default dump: 31×6 = 186 cycles, then 1 DONE cycle, so busy is high for 187 cycles.
- Outputs are registered or decoded from state only. No combinational path from out_ready or read_data to any output.
- The register file writes on the falling edge. A value written on the falling edge before a FETCH rising edge is captured by that FETCH.

## Test plan
- Reset dominance:
  - Stimulus: hold reset=0 for 3 cycles with start=1.
  - Required: busy=0, out_valid=0, done=0 throughout, and read_address=1.
- Single-register dump (FIRST_REG=LAST_REG=5, reg5=32'hDEADBEEF, out_ready=1):
  - Stimulus: start.
  - Required bytes: A5, EF, BE, AD, DE on 5 consecutive cycles.
  - Required: done pulses the cycle after DE is accepted.
- Backpressure (default parameters, reg1=32'h04030201):
  - Stimulus: deassert out_ready for 3 cycles while byte 02 is presented.
  - Required: out_data stays 02 and out_valid stays high. Stream resumes as A1, 01, 02, 03, 04 with no loss or duplication.
- Full dump (reg[i]=i×32'h01010101, out_ready=1):
  - Required: 155 bytes total; frame i has header 8'hA0|i followed by four bytes equal to i.
  - Required: busy high for exactly 187 cycles, done high once.
- Snapshot isolation:
  - Stimulus: write reg3=32'h11111111 during frame 3's SEND.
  - Required: frame 3 carries the old value, and the next dump carries 11 11 11 11.
- Abort and restart:
  - Stimulus: pulse reset=0 during frame 10, then issue start.
  - Required: no done pulse for the aborted dump, and the first byte after restart is header A1.
